// File: rtl/network_input_receive_pkg.sv
// Shared definitions for the GMII receive front end: frame limits, SFD byte,
// packet-buffer word flag encodings, FSM state codes and a word builder.
package network_input_receive_pkg;

   // Default frame limits (16-byte lines, bytes including FCS)
   localparam int DEF_MAX_LINES = 96;
   localparam int DEF_MIN_BYTES = 64;

   // Start-of-frame delimiter that ends the preamble
   localparam logic [7:0] SFD_BYTE = 8'hD5;

   // Packet-buffer word position flags, carried in word bits [133:132]
   typedef enum logic [1:0] {
      WORD_MID  = 2'b00,
      WORD_HEAD = 2'b01,
      WORD_TAIL = 2'b10,
      WORD_BOTH = 2'b11
   } word_flag_e;

   // Receive FSM state codes
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_RECV  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DISC  = 3'd4;

   // Assemble a 134-bit buffer word from flag, invalid-byte count and data
   function automatic logic [133:0] make_word(input word_flag_e flag,
                                              input logic [3:0] invalid,
                                              input logic [127:0] data);
      return {flag, invalid, data};
   endfunction

endpackage

// File: rtl/network_input_receive_if.sv
// Packet-buffer write bus and forwarding descriptor handshake leaving the
// receive front end. The receiver is the master, the buffer/forwarding side
// is the slave.
interface network_input_receive_if;

   logic [15:0]  ov_pkt_waddr;
   logic [133:0] ov_pkt_data;
   logic         o_pkt_data_wr;
   logic [47:0]  ov_tsntag;
   logic [2:0]   ov_pkt_type;
   logic [8:0]   ov_bufid;
   logic         o_descriptor_wr;
   logic         i_descriptor_ack;

   modport master (
      output ov_pkt_waddr,
      output ov_pkt_data,
      output o_pkt_data_wr,
      output ov_tsntag,
      output ov_pkt_type,
      output ov_bufid,
      output o_descriptor_wr,
      input  i_descriptor_ack
   );

   modport slave (
      input  ov_pkt_waddr,
      input  ov_pkt_data,
      input  o_pkt_data_wr,
      input  ov_tsntag,
      input  ov_pkt_type,
      input  ov_bufid,
      input  o_descriptor_wr,
      output i_descriptor_ack
   );

endinterface

// File: rtl/network_input_receive_rx_word_packer.sv
// Packs received frame bytes into 16-byte buffer words. Each completed word
// is held back one word-time so that the tail flag can be attached to the
// last word once the end of the frame is known.
module network_input_receive_rx_word_packer
   import network_input_receive_pkg::*;
#(
   parameter int MAX_LINES = DEF_MAX_LINES
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_byte_valid,
   input  logic [7:0]   iv_byte,
   input  logic         i_end,
   input  logic [8:0]   iv_bufid,
   output logic [15:0]  ov_waddr,
   output logic [133:0] ov_data,
   output logic         o_wr,
   output logic         o_tail_wr,
   output logic [10:0]  ov_byte_cnt
);

   logic [127:0] r_acc;
   logic [3:0]   r_idx;
   logic [10:0]  r_byte_cnt;
   logic [127:0] r_pend_data;
   logic         r_pend_valid;
   logic         r_pend_first;
   logic         r_flush;
   logic         r_flush_both;
   logic [6:0]   r_line;
   logic [15:0]  r_waddr;
   logic [133:0] r_data;
   logic         r_wr;
   logic         r_tail_wr;

   logic [127:0] w_full_word;
   logic [3:0]   w_invalid;
   logic [127:0] w_partial_data;
   logic [6:0]   w_line_next;
   word_flag_e   w_pend_flag;
   word_flag_e   w_last_flag;
   word_flag_e   w_flush_flag;

   // Word completed by the byte arriving this cycle (earliest byte on top)
   assign w_full_word    = {r_acc[119:0], iv_byte};
   // Partial word: left-justify the collected bytes, unused bytes stay zero
   assign w_invalid      = 4'(5'd16 - {1'b0, r_idx});
   assign w_partial_data = r_acc << {w_invalid, 3'b000};
   // Line counter stops at MAX_LINES instead of wrapping
   assign w_line_next    = (r_line < 7'(MAX_LINES)) ? r_line + 7'd1 : r_line;
   assign w_pend_flag    = r_pend_first ? WORD_HEAD : WORD_MID;
   assign w_last_flag    = r_pend_first ? WORD_BOTH : WORD_TAIL;
   assign w_flush_flag   = r_flush_both ? WORD_BOTH : WORD_TAIL;

   assign ov_waddr    = r_waddr;
   assign ov_data     = r_data;
   assign o_wr        = r_wr;
   assign o_tail_wr   = r_tail_wr;
   assign ov_byte_cnt = r_byte_cnt;

   // Accumulate bytes, emit delayed words and the final tail word
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc        <= '0;
         r_idx        <= '0;
         r_byte_cnt   <= '0;
         r_pend_data  <= '0;
         r_pend_valid <= 1'b0;
         r_pend_first <= 1'b0;
         r_flush      <= 1'b0;
         r_flush_both <= 1'b0;
         r_line       <= '0;
         r_waddr      <= '0;
         r_data       <= '0;
         r_wr         <= 1'b0;
         r_tail_wr    <= 1'b0;
      end else begin
         r_wr      <= 1'b0;
         r_tail_wr <= 1'b0;
         if (i_clear) begin
            r_acc        <= '0;
            r_idx        <= '0;
            r_byte_cnt   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_first <= 1'b0;
            r_flush      <= 1'b0;
            r_flush_both <= 1'b0;
            r_line       <= '0;
         end else if (i_byte_valid) begin
            if (r_byte_cnt != 11'h7FF) begin
               r_byte_cnt <= r_byte_cnt + 11'd1;
            end
            if (r_idx == 4'hF) begin
               // A new word is complete: release the previous one
               if (r_pend_valid) begin
                  r_wr    <= 1'b1;
                  r_waddr <= {iv_bufid, r_line};
                  r_data  <= make_word(w_pend_flag, 4'h0, r_pend_data);
                  r_line  <= w_line_next;
               end
               r_pend_data  <= w_full_word;
               r_pend_first <= ~r_pend_valid;
               r_pend_valid <= 1'b1;
               r_acc        <= '0;
               r_idx        <= '0;
            end else begin
               r_acc <= {r_acc[119:0], iv_byte};
               r_idx <= r_idx + 4'd1;
            end
         end else if (i_end) begin
            // Frame ended: the held word is either the tail or precedes one
            if (r_pend_valid) begin
               r_wr    <= 1'b1;
               r_waddr <= {iv_bufid, r_line};
               r_line  <= w_line_next;
               if (r_idx == 4'h0) begin
                  r_data    <= make_word(w_last_flag, 4'h0, r_pend_data);
                  r_tail_wr <= 1'b1;
               end else begin
                  r_data <= make_word(w_pend_flag, 4'h0, r_pend_data);
               end
            end
            if (r_idx != 4'h0) begin
               r_flush      <= 1'b1;
               r_flush_both <= ~r_pend_valid;
            end
            r_pend_valid <= 1'b0;
         end else if (r_flush) begin
            r_wr      <= 1'b1;
            r_tail_wr <= 1'b1;
            r_waddr   <= {iv_bufid, r_line};
            r_data    <= make_word(w_flush_flag, w_invalid, w_partial_data);
            r_line    <= w_line_next;
            r_flush   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/network_input_receive.sv
// Per-port GMII receive front end: strips preamble/SFD, writes the frame into
// a pre-fetched packet buffer and hands a descriptor to forwarding.
module network_input_receive
   import network_input_receive_pkg::*;
#(
   parameter int MAX_LINES = DEF_MAX_LINES,
   parameter int MIN_BYTES = DEF_MIN_BYTES
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [7:0]                     iv_gmii_rxd,
   input  logic                           i_gmii_rx_dv,
   input  logic                           i_gmii_rx_er,
   input  logic [8:0]                     iv_pkt_bufid,
   input  logic                           i_pkt_bufid_wr,
   output logic                           o_pkt_bufid_ack,
   network_input_receive_if.master        m_pkt_if,
   output logic                           o_pkt_input_pulse,
   output logic                           o_pkt_discard_pulse
);

   logic [2:0]   r_state;
   logic         r_input_pulse;
   logic         r_discard_pulse;
   logic         r_hold_full;
   logic [8:0]   r_hold_bufid;
   logic [47:0]  r_tag;
   logic         r_desc_wr;
   logic [47:0]  r_desc_tag;
   logic [8:0]   r_desc_bufid;

   logic [15:0]  w_waddr;
   logic [133:0] w_data;
   logic         w_wr;
   logic         w_tail_wr;
   logic [10:0]  w_byte_cnt;
   logic         w_oversize;
   logic         w_runt;
   logic         w_clear;
   logic         w_byte_valid;
   logic         w_end;
   logic         w_accept;

   // Frame length checks on the running byte count
   assign w_oversize   = (w_byte_cnt == 11'(MAX_LINES * 16));
   assign w_runt       = (w_byte_cnt < 11'(MIN_BYTES));
   // Packer only holds state while a frame is being received or flushed
   assign w_clear      = (r_state != ST_RECV) && (r_state != ST_FLUSH);
   assign w_byte_valid = (r_state == ST_RECV) && i_gmii_rx_dv && !i_gmii_rx_er && !w_oversize;
   assign w_end        = (r_state == ST_RECV) && !i_gmii_rx_dv && !w_runt;
   // The tail word is on the bus this cycle; hand over if the slot is free
   assign w_accept     = (r_state == ST_FLUSH) && w_tail_wr && !r_desc_wr;

   // Take an offered bufid whenever the holder is empty
   assign o_pkt_bufid_ack = ~i_rst & ~r_hold_full & i_pkt_bufid_wr;

   assign o_pkt_input_pulse   = r_input_pulse;
   assign o_pkt_discard_pulse = r_discard_pulse;

   assign m_pkt_if.ov_pkt_waddr    = w_waddr;
   assign m_pkt_if.ov_pkt_data     = w_data;
   assign m_pkt_if.o_pkt_data_wr   = w_wr;
   assign m_pkt_if.ov_tsntag       = r_desc_tag;
   assign m_pkt_if.ov_pkt_type     = r_desc_tag[47:45];
   assign m_pkt_if.ov_bufid        = r_desc_bufid;
   assign m_pkt_if.o_descriptor_wr = r_desc_wr;

   network_input_receive_rx_word_packer #(
      .MAX_LINES (MAX_LINES)
   ) u_packer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (w_clear),
      .i_byte_valid (w_byte_valid),
      .iv_byte      (iv_gmii_rxd),
      .i_end        (w_end),
      .iv_bufid     (r_hold_bufid),
      .ov_waddr     (w_waddr),
      .ov_data      (w_data),
      .o_wr         (w_wr),
      .o_tail_wr    (w_tail_wr),
      .ov_byte_cnt  (w_byte_cnt)
   );

   // Receive FSM with accept/discard pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= ST_IDLE;
         r_input_pulse   <= 1'b0;
         r_discard_pulse <= 1'b0;
      end else begin
         r_input_pulse   <= 1'b0;
         r_discard_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_gmii_rx_dv) begin
                  r_state <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (!i_gmii_rx_dv) begin
                  r_state <= ST_IDLE;
               end else if (iv_gmii_rxd == SFD_BYTE) begin
                  r_state <= r_hold_full ? ST_RECV : ST_DISC;
               end
            end
            ST_RECV: begin
               if (!i_gmii_rx_dv) begin
                  if (w_runt) begin
                     r_discard_pulse <= 1'b1;
                     r_state         <= ST_IDLE;
                  end else begin
                     r_state <= ST_FLUSH;
                  end
               end else if (i_gmii_rx_er || w_oversize) begin
                  r_state <= ST_DISC;
               end
            end
            ST_FLUSH: begin
               if (w_tail_wr) begin
                  r_input_pulse   <= ~r_desc_wr;
                  r_discard_pulse <= r_desc_wr;
                  r_state         <= ST_IDLE;
               end
            end
            ST_DISC: begin
               if (!i_gmii_rx_dv) begin
                  r_discard_pulse <= 1'b1;
                  r_state         <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Bufid holder: filled by the buffer manager, emptied by an accepted frame
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_full  <= 1'b0;
         r_hold_bufid <= '0;
      end else if (w_accept) begin
         r_hold_full <= 1'b0;
      end else if (!r_hold_full && i_pkt_bufid_wr) begin
         r_hold_full  <= 1'b1;
         r_hold_bufid <= iv_pkt_bufid;
      end
   end

   // Capture the first six frame bytes (destination MAC)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tag <= '0;
      end else if (w_byte_valid && (w_byte_cnt < 11'd6)) begin
         r_tag <= {r_tag[39:0], iv_gmii_rxd};
      end
   end

   // Descriptor register: a new load takes priority over an ack
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_desc_wr    <= 1'b0;
         r_desc_tag   <= '0;
         r_desc_bufid <= '0;
      end else if (w_accept) begin
         r_desc_wr    <= 1'b1;
         r_desc_tag   <= r_tag;
         r_desc_bufid <= r_hold_bufid;
      end else if (m_pkt_if.i_descriptor_ack) begin
         r_desc_wr <= 1'b0;
      end
   end

endmodule
